// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, opcode/funct constants, control field encodings and decode dispatch
package mc_pkg;
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXE_R   = 4'd2;
  localparam logic [3:0] S_EXE_I   = 4'd3;
  localparam logic [3:0] S_WB_R    = 4'd4;
  localparam logic [3:0] S_WB_I    = 4'd5;
  localparam logic [3:0] S_MEM_ADR = 4'd6;
  localparam logic [3:0] S_MEM_RD  = 4'd7;
  localparam logic [3:0] S_MEM_WR  = 4'd8;
  localparam logic [3:0] S_WB_MEM  = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_JAL     = 4'd12;
  localparam logic [3:0] S_JR      = 4'd13;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;
  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  // State following DECODE; S_FETCH means the instruction is unsupported
  function automatic logic [3:0] dispatch(input logic [5:0] op, input logic [5:0] funct);
    logic [3:0] s;
    case (op)
      OP_RTYPE: case (funct)
        F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT: s = S_EXE_R;
        F_JR:    s = S_JR;
        default: s = S_FETCH;
      endcase
      OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: s = S_EXE_I;
      OP_LW, OP_SW: s = S_MEM_ADR;
      OP_BEQ:  s = S_BRANCH;
      OP_J:    s = S_JUMP;
      OP_JAL:  s = S_JAL;
      default: s = S_FETCH;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational op/funct decode to ALU operation, immediate extension and overflow-checked class
module mc_alu_dec import mc_pkg::*; (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic [1:0] ext_op_o,
  output logic       ovf_op_o
);
  // R-type ops pick the ALU function from funct; I-type is ADD except ori
  always_comb begin
    alu_op_o = op_i == OP_ORI ? ALU_OR : ALU_ADD;
    if (op_i == OP_RTYPE)
      case (funct_i)
        F_SUB, F_SUBU: alu_op_o = ALU_SUB;
        F_AND:         alu_op_o = ALU_AND;
        F_OR:          alu_op_o = ALU_OR;
        F_SLT:         alu_op_o = ALU_SLT;
        default:       alu_op_o = ALU_ADD;
      endcase
  end

  assign ext_op_o = op_i == OP_LUI ? EXT_LUI : op_i == OP_ORI ? EXT_ZERO : EXT_SIGN;
  assign ovf_op_o = op_i == OP_ADDI || (op_i == OP_RTYPE && (funct_i == F_ADD || funct_i == F_SUB));
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM sequencing fetch, decode, execute, memory and writeback
module mc_ctrl import mc_pkg::*; #(
  parameter bit OVF_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       alu_of,
  input  logic       im_rdy,
  input  logic       dm_rdy,
  output logic       PCWr,
  output logic       IRWr,
  output logic       GPRWr,
  output logic       DMWr,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic       ALUSrc,
  output logic [1:0] ExtOp,
  output logic [2:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic       of,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);
  logic [3:0] state_q, state_d, disp;
  logic       ovf_q;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_ext_op;
  logic       dec_ovf_op;

  mc_alu_dec u_dec (
    .op_i     (op),
    .funct_i  (funct),
    .alu_op_o (dec_alu_op),
    .ext_op_o (dec_ext_op),
    .ovf_op_o (dec_ovf_op)
  );

  assign disp  = dispatch(op, funct);
  assign state = state_q;

  // Next-state selection, stalling on the memory ready handshakes
  always_comb begin
    case (state_q)
      S_FETCH:   state_d = im_rdy ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = disp;
      S_EXE_R:   state_d = S_WB_R;
      S_EXE_I:   state_d = S_WB_I;
      S_MEM_ADR: state_d = op == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = dm_rdy ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:  state_d = dm_rdy ? S_FETCH : S_MEM_WR;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register; overflow is latched in execute and dropped when the next fetch begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= state_d == S_FETCH ? 1'b0 :
                 (state_q == S_EXE_R || state_q == S_EXE_I) ? (alu_of & OVF_EN & dec_ovf_op) : ovf_q;
    end
  end

  // Moore output decode; everything is forced low while reset is asserted
  always_comb begin
    PCWr = 1'b0;
    IRWr = 1'b0;
    GPRWr = 1'b0;
    DMWr = 1'b0;
    RegDst = RD_RT;
    WDSel = WD_ALU;
    ALUSrc = 1'b0;
    ExtOp = EXT_ZERO;
    ALUOp = ALU_ADD;
    NPCOp = NPC_SEQ;
    of = 1'b0;
    instr_done = 1'b0;
    illegal = 1'b0;
    if (rst_n)
      case (state_q)
        S_FETCH: begin
          PCWr = im_rdy;
          IRWr = im_rdy;
        end
        S_DECODE: illegal = disp == S_FETCH;
        S_EXE_R:  ALUOp = dec_alu_op;
        S_EXE_I: begin
          ALUSrc = 1'b1;
          ExtOp = dec_ext_op;
          ALUOp = dec_alu_op;
        end
        S_WB_R, S_WB_I: begin
          RegDst = state_q == S_WB_R ? RD_RD : RD_RT;
          GPRWr = !ovf_q;
          of = ovf_q;
          instr_done = 1'b1;
        end
        S_MEM_ADR: begin
          ALUSrc = 1'b1;
          ExtOp = EXT_SIGN;
        end
        S_MEM_WR: begin
          DMWr = 1'b1;
          instr_done = dm_rdy;
        end
        S_WB_MEM: begin
          GPRWr = 1'b1;
          WDSel = WD_DM;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUOp = ALU_SUB;
          NPCOp = NPC_BR;
          PCWr = zero;
          instr_done = 1'b1;
        end
        S_JUMP, S_JAL: begin
          NPCOp = NPC_J;
          PCWr = 1'b1;
          instr_done = 1'b1;
          GPRWr = state_q == S_JAL;
          RegDst = state_q == S_JAL ? RD_RA : RD_RT;
          WDSel = state_q == S_JAL ? WD_PC4 : WD_ALU;
        end
        S_JR: begin
          NPCOp = NPC_JR;
          PCWr = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized scoreboard bench for the multicycle control FSM
module tb_mc_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0, alu_of = 1'b0, im_rdy = 1'b0, dm_rdy = 1'b0;
  logic PCWr, IRWr, GPRWr, DMWr, ALUSrc, of, instr_done, illegal;
  logic [1:0] RegDst, WDSel, ExtOp, NPCOp;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic z_pcwr, z_irwr, z_gprwr, z_dmwr, z_alusrc, z_of, z_done, z_ill;
  logic [1:0] z_regdst, z_wdsel, z_extop, z_npcop;
  logic [2:0] z_aluop;
  logic [3:0] z_state;
  logic [22:0] outs;
  int total = 0, bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  mc_ctrl #(.OVF_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .alu_of(alu_of),
    .im_rdy(im_rdy), .dm_rdy(dm_rdy), .PCWr(PCWr), .IRWr(IRWr), .GPRWr(GPRWr), .DMWr(DMWr),
    .RegDst(RegDst), .WDSel(WDSel), .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .of(of), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  mc_ctrl #(.OVF_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .alu_of(alu_of),
    .im_rdy(im_rdy), .dm_rdy(dm_rdy), .PCWr(z_pcwr), .IRWr(z_irwr), .GPRWr(z_gprwr), .DMWr(z_dmwr),
    .RegDst(z_regdst), .WDSel(z_wdsel), .ALUSrc(z_alusrc), .ExtOp(z_extop), .ALUOp(z_aluop), .NPCOp(z_npcop),
    .of(z_of), .instr_done(z_done), .illegal(z_ill), .state(z_state)
  );

  assign outs = {PCWr, IRWr, GPRWr, DMWr, RegDst, WDSel, ALUSrc, ExtOp, ALUOp, NPCOp, of, instr_done, illegal, state};

  typedef struct {
    int lat, wr, ofc, rd, wd, dmw, pcw, npc, alu, ext, src, ill, wr0;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Per-instruction expectations from the instruction class, wait states and flags
  function automatic exp_t model(input int o, input int f, input int imw, input int dmw, input bit z, input bit aof);
    exp_t e = '{default: 0};
    bit ov = 1'b0;
    e.pcw = 1;
    e.lat = imw;
    if (o == 0 && f inside {32, 33, 34, 35, 36, 37, 42}) begin
      e.lat += 4; e.rd = 1; e.wr0 = 1;
      e.alu = (f == 34 || f == 35) ? 1 : f == 36 ? 2 : f == 37 ? 3 : f == 42 ? 4 : 0;
      ov = aof && (f == 32 || f == 34);
    end else if (o == 0 && f == 8) begin
      e.lat += 3; e.pcw = 2; e.npc = 3;
    end else if (o inside {8, 9, 13, 15}) begin
      e.lat += 4; e.wr0 = 1; e.src = 1;
      e.alu = o == 13 ? 3 : 0;
      e.ext = o == 13 ? 0 : o == 15 ? 2 : 1;
      ov = aof && o == 8;
    end else if (o == 35) begin
      e.lat += 5 + dmw; e.wr0 = 1; e.wd = 1; e.src = 1; e.ext = 1;
    end else if (o == 43) begin
      e.lat += 4 + dmw; e.dmw = dmw + 1; e.src = 1; e.ext = 1;
    end else if (o == 4) begin
      e.lat += 3; e.alu = 1; e.npc = 1; e.pcw = 1 + int'(z);
    end else if (o == 2 || o == 3) begin
      e.lat += 3; e.pcw = 2; e.npc = 2;
      if (o == 3) begin e.wr0 = 1; e.rd = 2; e.wd = 2; end
    end else begin
      e.lat += 2; e.ill = 1;
    end
    e.wr = (e.wr0 == 1 && !ov) ? 1 : 0;
    e.ofc = int'(ov);
    return e;
  endfunction

  task automatic run_instr(input int o, input int f, input int imw, input int dmw, input bit z, input bit aof);
    exp_t e = model(o, f, imw, dmw, z, aof);
    sb.push_back(e);
    for (int c = 0; c < e.lat; c++) begin
      op = 6'(o);
      funct = 6'(f);
      im_rdy = c < imw ? 1'b0 : c == imw ? 1'b1 : 1'($urandom);
      dm_rdy = c >= imw + 3 ? (c - imw - 3 >= dmw) : 1'($urandom);
      zero = c == imw + 2 ? z : 1'($urandom);
      alu_of = c == imw + 2 ? aof : 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  int cyc, k, wr, ofc, dmw, pcw, irw, ill, wr0, of0, rd, wd, alu, ext, src, npc;

  task automatic mon_clear();
    cyc = 0; k = -1; wr = 0; ofc = 0; dmw = 0; pcw = 0; irw = 0; ill = 0;
    wr0 = 0; of0 = 0; rd = 0; wd = 0; alu = 0; ext = 0; src = 0; npc = 0;
  endtask

  // Monitor: accumulate per-instruction activity, compare when an instruction ends
  initial begin
    exp_t e;
    mon_clear();
    forever begin
      @(negedge clk);
      if (!mon_en) mon_clear();
      else begin
        cyc++;
        k = IRWr ? 0 : (k >= 0 ? k + 1 : -1);
        if (k == 2) begin alu = int'(ALUOp); ext = int'(ExtOp); src = int'(ALUSrc); end
        wr += int'(GPRWr); ofc += int'(of); dmw += int'(DMWr); pcw += int'(PCWr);
        irw += int'(IRWr); ill += int'(illegal); wr0 += int'(z_gprwr); of0 += int'(z_of);
        if (GPRWr || of) begin rd = int'(RegDst); wd = int'(WDSel); end
        if (instr_done || illegal) begin
          npc = int'(NPCOp);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_done: got end of instruction with state %0d, expected none", state);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc, e.lat);
            chk("gprwr_cnt", wr, e.wr);
            chk("of_cnt", ofc, e.ofc);
            chk("regdst", rd, e.rd);
            chk("wdsel", wd, e.wd);
            chk("dmwr_cnt", dmw, e.dmw);
            chk("pcwr_cnt", pcw, e.pcw);
            chk("irwr_cnt", irw, 1);
            chk("npcop_end", npc, e.npc);
            chk("aluop", alu, e.alu);
            chk("extop", ext, e.ext);
            chk("alusrc", src, e.src);
            chk("illegal", ill, e.ill);
            chk("noovf_gprwr", wr0, e.wr0);
            chk("noovf_of", of0, 0);
          end
          mon_clear();
        end
      end
    end
  end

  int d_op[18] = '{0, 0, 0, 0, 8, 35, 4, 4, 43, 3, 63, 0, 2, 15, 13, 0, 0, 0};
  int d_fn[18] = '{33, 32, 33, 34, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 42, 36, 37};
  int d_dw[18] = '{0, 0, 0, 0, 0, 3, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  bit d_z[18]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  bit d_of[18] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int r_op[14] = '{0, 0, 0, 2, 3, 4, 8, 9, 13, 15, 35, 43, 63, 1};
  int r_fn[10] = '{32, 33, 34, 35, 36, 37, 42, 8, 0, 38};

  initial begin
    im_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outs", int'(outs), 0);
    op = 6'h23;
    rst_n = 1'b1;
    #1;
    chk("release_fetch", int'({PCWr, IRWr}), 3);
    repeat (3) @(posedge clk);
    #2;
    chk("reach_memrd", int'(state), 7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_in_memrd", int'(outs), 0);
    rst_n = 1'b1;
    #1;
    chk("release2_fetch", int'({PCWr, IRWr}), 3);
    im_rdy = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 18; i++) run_instr(d_op[i], d_fn[i], 0, d_dw[i], d_z[i], d_of[i]);
    for (int i = 0; i < 200; i++)
      run_instr(r_op[$urandom_range(13)], r_fn[$urandom_range(9)], $urandom_range(2),
                $urandom_range(3), 1'($urandom), 1'($urandom));
    im_rdy = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle control FSM for the MIPS datapath. It sequences the PC, IR, ALU, data memory and the GPR register file across FETCH/DECODE/EXE/MEM/WB states. It drives GPRWr, the write-register select, the write-data select and the overflow flag (of) into the GPR. It waits on instruction-memory and data-memory ready handshakes.

Parameters:
OVF_EN, 1, 1 = signed add/addi/sub overflow suppresses the rd/rt write and pulses of (GPR sets $30=1); 0 = overflow ignored.

Ports:
clk  in  1  system clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], stable from DECODE until instruction end
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (combinational)
alu_of  in  1  ALU signed-overflow flag (combinational)
im_rdy  in  1  instruction memory data valid
dm_rdy  in  1  data memory access complete
PCWr  out  1  PC write enable
IRWr  out  1  IR write enable
GPRWr  out  1  GPR write enable
DMWr  out  1  data memory write enable
RegDst  out  2  write register: 0 rt, 1 rd, 2 $31
WDSel  out  2  write data: 0 ALU result, 1 DM read data, 2 PC+4
ALUSrc  out  1  ALU B operand: 0 GPR B, 1 extended immediate
ExtOp  out  2  0 zero-extend, 1 sign-extend, 2 imm<<16
ALUOp  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
NPCOp  out  2  0 PC+4, 1 branch, 2 jump target, 3 GPR[rs]
of  out  1  overflow write strobe to GPR
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal  out  1  one-cycle pulse when DECODE sees an unsupported op/funct
state  out  4  current state, for debug

Behaviour:
- Reset (rst_n=0, any state, including a stalled memory wait): state=FETCH; ovf_q=0; every output 0 while rst_n is low.
- After release, the first edge is evaluated in FETCH.
- Outputs are Moore, decoded from state plus op/funct; the only other input terms are the im_rdy, dm_rdy and zero gating listed below.
- Any signal not listed for a state is 0.
- FETCH: PCWr=IRWr=im_rdy, NPCOp=0. Hold while im_rdy=0; go to DECODE when im_rdy=1.
- DECODE dispatch:
  - R-type (op 0) with funct add/addu/sub/subu/and/or/slt (20,21,22,23,24,25,2A) -> EXE_R
  - R-type funct jr (08) -> JR
  - addi/addiu/ori/lui (08,09,0D,0F) -> EXE_I
  - lw/sw (23,2B) -> MEM_ADR
  - beq (04) -> BRANCH
  - j (02) -> JUMP
  - jal (03) -> JAL
  - anything else: illegal=1, next state FETCH
- EXE_R: ALUSrc=0, ALUOp from funct (addu/add ADD, subu/sub SUB, and AND, or OR, slt SLT). Next state WB_R.
- EXE_I: ALUSrc=1; ExtOp=1 for addi/addiu, 0 for ori, 2 for lui; ALUOp ADD, except OR for ori. Next state WB_I.
- Overflow capture: in EXE_R/EXE_I, ovf_q <= alu_of & OVF_EN & (op/funct is add, sub or addi). ovf_q clears on entry to FETCH.
- WB_R / WB_I: RegDst=1 or 0 respectively, WDSel=0. If ovf_q: GPRWr=0 and of=1; else GPRWr=1. instr_done=1. Next state FETCH.
- MEM_ADR: ALUSrc=1, ExtOp=1, ALUOp=ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: hold until dm_rdy=1, then WB_MEM.
- MEM_WR: DMWr=1 every cycle until dm_rdy=1; then instr_done=1 and next state FETCH.
- WB_MEM: GPRWr=1, RegDst=0, WDSel=1, instr_done=1. Next state FETCH.
- BRANCH: ALUSrc=0, ALUOp=SUB, NPCOp=1, PCWr=zero, instr_done=1. Next state FETCH.
- JUMP: NPCOp=2, PCWr=1, instr_done=1.
- JAL: same as JUMP, plus GPRWr=1, RegDst=2, WDSel=2 in the same cycle.
- JR: NPCOp=3, PCWr=1, instr_done=1.
- Latency with zero wait states, counting FETCH as cycle 0: R/I 4 cycles, lw 5, sw 4, beq/j/jal/jr 3. Each cycle of im_rdy=0 or dm_rdy=0 adds one cycle.
- GPRWr is high for at most one cycle per instruction. GPRWr and of are never both high.

Decomposition:
- Package mc_pkg holds the state encoding localparams (FETCH..JR, 4-bit), opcode and funct constants, and the ALUOp/ExtOp/NPCOp/RegDst/WDSel encodings.
- Sub-module mc_alu_dec is natural: a combinational decoder from op/funct to ALUOp/ExtOp.
- mc_ctrl holds the state register, ovf_q and the output decode.

Test Plan:
1. Reset during MEM_RD with dm_rdy=0 -> state=FETCH and all outputs 0 immediately; after rst_n=1 with im_rdy=1 -> PCWr=IRWr=1.
2. addu (op 00, funct 21), ready inputs high -> GPRWr=1, RegDst=1, WDSel=0 in cycle 3 only; instr_done in cycle 3; next fetch in cycle 4.
3. Overflow, OVF_EN=1:
   - add with alu_of=1 in EXE -> WB cycle has GPRWr=0, of=1.
   - Same with addu -> GPRWr=1, of=0.
   - OVF_EN=0 with add -> GPRWr=1, of=0.
4. lw with dm_rdy held 0 for 3 cycles in MEM_RD -> GPRWr=1, WDSel=1, RegDst=0 exactly one cycle after dm_rdy rises; total 8 cycles.
5. beq with zero=0 -> PCWr=0; with zero=1 -> PCWr=1 and NPCOp=1. sw with dm_rdy delayed 2 cycles -> DMWr high for 3 cycles.
6. jal -> PCWr=GPRWr=1, RegDst=2, WDSel=2, NPCOp=2 in cycle 2. op 3F -> illegal pulse in DECODE, FETCH in cycle 2, no GPRWr/DMWr/PCWr.
